// File: rtl/ysyx_22040759_if_fetch.sv
// ysyx_22040759_if_fetch -- instruction-fetch stage.
//
// Holds the PC and fetches one instruction at a time over a split
// address/data memory handshake. At most one request is ever outstanding.
// The fetched {inst, pc} goes into a one-entry output register that feeds
// the decode stage. A taken branch flushes that register and cancels any
// fetch that is still in flight.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   ds_allowin      decode stage can accept the bus this cycle
//   fs_to_ds_valid  fs_to_ds_bus holds a valid instruction
//   fs_to_ds_bus    {inst[95:64], pc[63:0]}
//   br_bus          {br_taken[64], br_target[63:0]}; br_taken is a pulse
//   inst_req        fetch request (address phase)
//   inst_addr       fetch address, held while inst_req & !inst_addr_ok
//   inst_addr_ok    address accepted this cycle
//   inst_data_ok    read data valid this cycle
//   inst_rdata      returned instruction word
module ysyx_22040759_if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [95:0] fs_to_ds_bus,
  input  logic [64:0] br_bus,
  output logic        inst_req,
  output logic [63:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic        cancel_q, cancel_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic        req_hold_q, req_hold_d;
  logic        valid_q, valid_d;
  logic [95:0] bus_q, bus_d;

  logic        br_taken;
  logic [63:0] br_target;
  logic        handshake;

  assign br_taken  = br_bus[64];
  assign br_target = br_bus[63:0] & ~64'h3;
  assign handshake = inst_req & inst_addr_ok;

  assign fs_to_ds_valid = valid_q;
  assign fs_to_ds_bus   = bus_q;

  // A raised request is held (same address) until accepted, even across a
  // redirect or a drop of ds_allowin; only a fresh request looks at them.
  always_comb begin
    inst_req = 1'b0;
    if (!rst && state_q == S_REQ) begin
      inst_req = req_hold_q || (!br_taken && (!valid_q || ds_allowin));
    end
    inst_addr = req_hold_q ? fetch_pc_q : (pc_q & ~64'h3);
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    fetch_pc_d         = fetch_pc_q;
    cancel_d           = cancel_q;
    redirect_pending_d = redirect_pending_q;
    valid_d            = valid_q;
    bus_d              = bus_q;
    req_hold_d         = inst_req && !inst_addr_ok;

    // The address is captured the first cycle a request is raised; while it
    // is held, fetch_pc already carries it.
    if (inst_req && !req_hold_q) begin
      fetch_pc_d = inst_addr;
    end

    if (valid_q && ds_allowin) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (handshake) begin
          state_d            = S_WAIT;
          // A redirect seen while the address was stalled (or in the very
          // accepting cycle) turns this fetch into one to be discarded.
          cancel_d           = redirect_pending_q || br_taken;
          redirect_pending_d = 1'b0;
        end else if (br_taken && inst_req) begin
          redirect_pending_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d  = S_REQ;
          cancel_d = 1'b0;
          // A cancelled response leaves pc alone: it already holds the
          // latest redirect target.
          if (!cancel_q && !br_taken) begin
            bus_d   = {inst_rdata, fetch_pc_q};
            valid_d = 1'b1;
            pc_d    = fetch_pc_q + 64'd4;
          end
        end else if (br_taken) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything else in the cycle.
    if (br_taken) begin
      valid_d = 1'b0;
      pc_d    = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_REQ;
      pc_q               <= RESET_PC;
      fetch_pc_q         <= RESET_PC;
      cancel_q           <= 1'b0;
      redirect_pending_q <= 1'b0;
      req_hold_q         <= 1'b0;
      valid_q            <= 1'b0;
      bus_q              <= 96'd0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      fetch_pc_q         <= fetch_pc_d;
      cancel_q           <= cancel_d;
      redirect_pending_q <= redirect_pending_d;
      req_hold_q         <= req_hold_d;
      valid_q            <= valid_d;
      bus_q              <= bus_d;
    end
  end

endmodule
